// File: rtl/sdu_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// The FIFO depth is 2^FIFO_AW. txd is registered, so it follows the FSM state one cycle later.
module sdu_uart_tx #(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         din,
  input  logic               din_vld,
  output logic               din_rdy,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_cnt
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        bit_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic [7:0]           mem [0:(1 << FIFO_AW) - 1];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 bit_end;

  // Ready comes only from the registered count, so a pop in the same cycle never frees a slot early.
  assign din_rdy = fifo_cnt < DEPTH;
  assign push    = din_vld && din_rdy;
  assign bit_end = bit_cnt == BIT_LAST;
  assign pop     = (fifo_cnt != '0) && ((state == IDLE) || (state == STOP && bit_end));
  assign busy    = (state != IDLE) || (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
        shift  <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          txd     <= 1'b1;
          bit_cnt <= '0;
          if (pop) state <= START;
        end
        START: begin
          txd <= 1'b0;
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          txd <= shift[bit_idx];
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          txd <= 1'b1;
          // A queued byte chains straight into the next start bit with no idle gap.
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= pop ? START : IDLE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
